// File: rtl/pcie_tl_router_if.sv
// Bus bundle between the transaction-layer router and its input/output FIFOs.
// The master side is the FIFO environment; the slave side is the router.
interface pcie_tl_router_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 10
);
  logic                          enable;
  logic [NUM_PORTS-1:0]          in_empty;
  logic [NUM_PORTS*DATA_W-1:0]   in_data;
  logic [NUM_PORTS-1:0]          in_pop;
  logic [NUM_PORTS-1:0]          out_afull;
  logic [NUM_PORTS-1:0]          out_push;
  logic [NUM_PORTS*DATA_W-1:0]   out_data;
  logic                          busy;
  logic [15:0]                   pkt_count;

  modport master (
    output enable, in_empty, in_data, out_afull,
    input  in_pop, out_push, out_data, busy, pkt_count
  );

  modport slave (
    input  enable, in_empty, in_data, out_afull,
    output in_pop, out_push, out_data, busy, pkt_count
  );
endinterface

// File: rtl/pcie_tl_router.sv
// Transaction-layer router: moves one word per cycle from NUM_PORTS input
// FIFOs to NUM_PORTS output FIFOs over a shared channel. The destination is
// the top log2(NUM_PORTS) bits of each word. The pop is combinational in the
// grant cycle; the push is registered and appears one cycle later.
module pcie_tl_router #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 10,
  parameter bit RR_EN     = 1'b0
) (
  input logic             clk,
  input logic             reset_L,
  pcie_tl_router_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_PORTS);
  typedef logic [SEL_W-1:0] sel_t;

  logic [NUM_PORTS-1:0]        elig_s;
  logic [NUM_PORTS-1:0]        pop_s;
  logic                        grant_vld_s;
  sel_t                        grant_idx_s;
  sel_t                        cand_s;
  logic [DATA_W-1:0]           grant_word_s;
  sel_t                        grant_dest_s;
  logic [NUM_PORTS-1:0]        push_nxt_s;
  logic [NUM_PORTS*DATA_W-1:0] data_nxt_s;
  logic [NUM_PORTS-1:0]        push_r;
  logic [NUM_PORTS*DATA_W-1:0] data_r;
  logic [15:0]                 cnt_r;
  sel_t                        rr_ptr_r;

  // Destination field carried in the top bits of a word.
  function automatic sel_t dest_of(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: SEL_W];
  endfunction

  // An input is eligible when it holds a word and its target output has room.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.enable && reset_L && !bus.in_empty[i] &&
          !bus.out_afull[dest_of(bus.in_data[i*DATA_W +: DATA_W])]) begin
        elig_s[i] = 1'b1;
      end else begin
        elig_s[i] = 1'b0;
      end
    end
  end

  // Pick one eligible input: lowest index, or first after rr_ptr in round-robin.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (RR_EN) begin
        // Power-of-2 port count: the SEL_W-bit sum wraps modulo NUM_PORTS.
        cand_s = rr_ptr_r + sel_t'(k);
      end else begin
        cand_s = sel_t'(k - 1);
      end
      if (!grant_vld_s && elig_s[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Pop strobe for the winner and the push/data values to register next edge.
  always_comb begin
    pop_s        = '0;
    push_nxt_s   = '0;
    data_nxt_s   = '0;
    grant_word_s = bus.in_data[grant_idx_s*DATA_W +: DATA_W];
    grant_dest_s = dest_of(grant_word_s);
    if (grant_vld_s) begin
      pop_s[grant_idx_s]                          = 1'b1;
      push_nxt_s[grant_dest_s]                    = 1'b1;
      data_nxt_s[grant_dest_s*DATA_W +: DATA_W]   = grant_word_s;
    end else begin
      pop_s      = '0;
      push_nxt_s = '0;
      data_nxt_s = '0;
    end
  end

  // Registered output stage, routed-word counter and round-robin pointer.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_r   <= '0;
      data_r   <= '0;
      cnt_r    <= 16'h0000;
      rr_ptr_r <= sel_t'(NUM_PORTS - 1);
    end else begin
      push_r <= push_nxt_s;
      data_r <= data_nxt_s;
      if (grant_vld_s) begin
        cnt_r    <= cnt_r + 16'd1;
        rr_ptr_r <= grant_idx_s;
      end
    end
  end

  assign bus.in_pop    = pop_s;
  assign bus.out_push  = push_r;
  assign bus.out_data  = data_r;
  assign bus.pkt_count = cnt_r;
  assign bus.busy      = (|push_r) | ~(&bus.in_empty);

endmodule

// File: tb/tb_pcie_tl_router.sv
// Directed bench for pcie_tl_router: one fixed-priority and one round-robin
// instance share the same stimulus; expected values are hand-computed.
module tb_pcie_tl_router;
  logic        clk;
  logic        reset_L;
  logic        enable;
  logic [3:0]  in_empty;
  logic [39:0] in_data;
  logic [3:0]  out_afull;
  int          tests;
  int          fails;
  logic [3:0]  exp4;
  logic [9:0]  words [4];
  logic [39:0] stream;

  pcie_tl_router_if #(.NUM_PORTS(4), .DATA_W(10)) bus_fp ();
  pcie_tl_router_if #(.NUM_PORTS(4), .DATA_W(10)) bus_rr ();

  assign bus_fp.enable    = enable;
  assign bus_fp.in_empty  = in_empty;
  assign bus_fp.in_data   = in_data;
  assign bus_fp.out_afull = out_afull;
  assign bus_rr.enable    = enable;
  assign bus_rr.in_empty  = in_empty;
  assign bus_rr.in_data   = in_data;
  assign bus_rr.out_afull = out_afull;

  pcie_tl_router #(.NUM_PORTS(4), .DATA_W(10), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset_L(reset_L), .bus(bus_fp)
  );
  pcie_tl_router #(.NUM_PORTS(4), .DATA_W(10), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .reset_L(reset_L), .bus(bus_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] at_slot(input int j, input logic [9:0] w);
    return 40'(w) << (10 * j);
  endfunction

  task automatic do_reset();
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    words[0]  = 10'h010;
    words[1]  = 10'h111;
    words[2]  = 10'h212;
    words[3]  = 10'h313;
    stream    = {words[3], words[2], words[1], words[0]};
    reset_L   = 1'b0;
    enable    = 1'b1;
    in_empty  = 4'b0000;
    in_data   = stream;
    out_afull = 4'b0000;

    // Reset held with every input non-empty and enable high
    tick();
    tick();
    check("rst_pop",   64'(bus_fp.in_pop),    64'h0);
    check("rst_pop_rr",64'(bus_rr.in_pop),    64'h0);
    check("rst_push",  64'(bus_fp.out_push),  64'h0);
    check("rst_data",  64'(bus_fp.out_data),  64'h0);
    check("rst_cnt",   64'(bus_fp.pkt_count), 64'h0);
    check("rst_busy",  64'(bus_fp.busy),      64'h1);

    // Single word: only port 2, head 0x305 -> destination 3
    reset_L  = 1'b1;
    in_empty = 4'b1011;
    in_data  = at_slot(2, 10'h305);
    #1;
    check("single_pop",    64'(bus_fp.in_pop), 64'h4);
    check("single_pop_rr", 64'(bus_rr.in_pop), 64'h4);
    tick();
    in_empty = 4'b1111;
    check("single_push", 64'(bus_fp.out_push),  64'h8);
    check("single_data", 64'(bus_fp.out_data),  64'(at_slot(3, 10'h305)));
    check("single_cnt",  64'(bus_fp.pkt_count), 64'h1);
    check("single_busy", 64'(bus_fp.busy),      64'h1);
    tick();
    check("idle_push", 64'(bus_fp.out_push), 64'h0);
    check("idle_data", 64'(bus_fp.out_data), 64'h0);
    check("idle_busy", 64'(bus_fp.busy),     64'h0);

    // Fixed priority: all non-empty, distinct destinations
    in_empty = 4'b0000;
    in_data  = stream;
    #1;
    check("fp_pop0", 64'(bus_fp.in_pop), 64'h1);
    tick();
    check("fp_push0", 64'(bus_fp.out_push), 64'h1);
    check("fp_data0", 64'(bus_fp.out_data), 64'(at_slot(0, 10'h010)));
    check("fp_pop0b", 64'(bus_fp.in_pop),   64'h1);
    tick();
    in_empty = 4'b0001;
    #1;
    check("fp_pop1", 64'(bus_fp.in_pop), 64'h2);
    tick();
    in_empty = 4'b1111;
    check("fp_push1", 64'(bus_fp.out_push),  64'h2);
    check("fp_data1", 64'(bus_fp.out_data),  64'(at_slot(1, 10'h111)));
    check("fp_cnt",   64'(bus_fp.pkt_count), 64'h4);

    // Round-robin: all non-empty, grants 0,1,2,3,0,1
    do_reset();
    in_empty = 4'b0000;
    in_data  = stream;
    for (int k = 0; k < 6; k++) begin
      exp4 = 4'b0001 << (k % 4);
      #1;
      check("rr_pop", 64'(bus_rr.in_pop), 64'(exp4));
      tick();
      check("rr_push", 64'(bus_rr.out_push), 64'(exp4));
      check("rr_data", 64'(bus_rr.out_data), 64'(at_slot(k % 4, words[k % 4])));
    end
    check("rr_cnt",    64'(bus_rr.pkt_count), 64'h6);
    check("rr_fp_cnt", 64'(bus_fp.pkt_count), 64'h6);
    check("rr_fp_push",64'(bus_fp.out_push),  64'h1);

    // Backpressure: port 0 -> dest 1 (almost full), port 1 -> dest 2
    do_reset();
    in_empty  = 4'b1100;
    in_data   = at_slot(0, 10'h1AA) | at_slot(1, 10'h255);
    out_afull = 4'b0010;
    #1;
    check("bp_pop1", 64'(bus_fp.in_pop), 64'h2);
    tick();
    check("bp_push2", 64'(bus_fp.out_push), 64'h4);
    check("bp_data2", 64'(bus_fp.out_data), 64'(at_slot(2, 10'h255)));
    out_afull = 4'b0000;
    in_empty  = 4'b1110;
    #1;
    check("bp_pop0", 64'(bus_fp.in_pop), 64'h1);
    tick();
    in_empty = 4'b1111;
    check("bp_push1", 64'(bus_fp.out_push),  64'h2);
    check("bp_data1", 64'(bus_fp.out_data),  64'(at_slot(1, 10'h1AA)));
    check("bp_cnt",   64'(bus_fp.pkt_count), 64'h2);

    // Asynchronous reset between edges while a push is pending
    #3;
    reset_L = 1'b0;
    #1;
    check("arst_push", 64'(bus_fp.out_push),  64'h0);
    check("arst_data", 64'(bus_fp.out_data),  64'h0);
    check("arst_cnt",  64'(bus_fp.pkt_count), 64'h0);
    check("arst_cnt_rr", 64'(bus_rr.pkt_count), 64'h0);
    tick();
    reset_L = 1'b1;

    // enable drops mid-stream: no pop that cycle, final push still lands
    in_empty = 4'b0000;
    in_data  = stream;
    enable   = 1'b1;
    tick();
    enable = 1'b0;
    #1;
    check("en_pop",   64'(bus_fp.in_pop),   64'h0);
    check("en_final", 64'(bus_fp.out_push), 64'h1);
    tick();
    check("en_push_off", 64'(bus_fp.out_push),  64'h0);
    check("en_data_off", 64'(bus_fp.out_data),  64'h0);
    check("en_cnt",      64'(bus_fp.pkt_count), 64'h1);
    enable = 1'b1;

    // Counter wrap: 65535 words, then one more
    do_reset();
    in_empty = 4'b0000;
    repeat (65535) tick();
    check("wrap_ffff", 64'(bus_fp.pkt_count), 64'hFFFF);
    tick();
    check("wrap_zero",    64'(bus_fp.pkt_count), 64'h0);
    check("wrap_zero_rr", 64'(bus_rr.pkt_count), 64'h0);
    check("wrap_push",    64'(bus_fp.out_push),  64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pcie_tl_router.md
# pcie_tl_router

Parametrised transaction-layer router that moves words from NUM_PORTS input FIFOs to NUM_PORTS output FIFOs over a single shared internal channel. Each word carries its destination in its top log2(NUM_PORTS) bits. It replaces the fixed 4-port combinational mux with an explicit empty/almost-full handshake, selectable fixed-priority or round-robin arbitration, a registered output stage and a routed-word counter. It sits between the per-VC input FIFOs and the per-destination output FIFOs of the transaction layer.

## Interface

Parameters:
- NUM_PORTS, 4, input and output port count; power of 2, 2..8.
- DATA_W, 10, word width; must be greater than log2(NUM_PORTS).
- RR_EN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- enable  in  1  1 = new grants allowed; 0 = no new pops.
- in_empty  in  NUM_PORTS  empty flag of input FIFO i.
- in_data  in  NUM_PORTS*DATA_W  show-ahead head word of input FIFO i at [i*DATA_W +: DATA_W].
- in_pop  out  NUM_PORTS  pop strobe to input FIFO i; at most one bit set.
- out_afull  in  NUM_PORTS  almost-full flag of output FIFO j.
- out_push  out  NUM_PORTS  push strobe to output FIFO j; at most one bit set.
- out_data  out  NUM_PORTS*DATA_W  word for output FIFO j at [j*DATA_W +: DATA_W].
- busy  out  1  1 while a push is pending or any input is non-empty.
- pkt_count  out  16  total words routed; wraps.

## Operation

- dest(i) = in_data[i*DATA_W + DATA_W-1 -: log2(NUM_PORTS)].
- Input i is eligible when enable=1, reset_L=1, in_empty[i]=0 and out_afull[dest(i)]=0.
- An all-zero word is legal data. Validity comes only from in_empty.
- Each cycle at most one eligible input is granted:
  - RR_EN=0: lowest eligible index.
  - RR_EN=1: first eligible index searching upward, modulo NUM_PORTS, from rr_ptr+1.
  - rr_ptr is loaded with the granted index on a grant and holds otherwise.
- Grant g raises in_pop[g] combinationally in the same cycle.
- On the next edge the router registers the word and its destination d. It then drives out_push to one-hot d and out_data[d] = word. All other out_data slices are 0.
- With no grant in a cycle: out_push is 0 and all out_data are 0 on the following cycle.
- pkt_count increments by 1 on every registered push and wraps from 0xFFFF to 0x0000.
- busy = |out_push | ~&in_empty.
- enable deasserted mid-stream: in_pop is 0 in that same cycle. A push already registered still completes.
- Reset, asynchronous and mid-operation included: out_push=0, all out_data=0, in_pop=0, pkt_count=0, rr_ptr=NUM_PORTS-1 so the first round-robin grant goes to port 0. Any in-flight word is discarded.

## Timing

- in_pop is a Mealy output of in_empty, in_data, out_afull, enable and rr_ptr. There are no registers on that path.
- Latency: pop in cycle N gives push in cycle N+1.
- Aggregate throughput: 1 word per cycle. Per-output throughput is 1 word per cycle.
- Output FIFOs must assert out_afull while 2 or fewer slots are free. This covers the one in-flight word. out_afull is sampled only in the grant cycle.
- Simultaneous events: for contending inputs with the same destination, the arbitration rule decides. An ineligible input never blocks others; there is no head-of-line blocking across ports.

## Test plan

- Reset: hold reset_L=0 with all inputs non-empty and enable=1 -> in_pop=0, out_push=0, out_data=0, pkt_count=0. Assert reset_L=0 asynchronously mid-stream -> outputs clear immediately.
- Single word, NUM_PORTS=4, DATA_W=10: only port 2 non-empty with head 0x305 (dest 3) -> cycle N in_pop=0100; cycle N+1 out_push=1000, out_data[3]=0x305, pkt_count=1.
- Fixed priority, RR_EN=0: all four ports non-empty continuously, destinations distinct -> in_pop=0001 every cycle until port 0 empties, then 0010.
- Round-robin, RR_EN=1: all ports non-empty continuously -> grant sequence 0,1,2,3,0,1 over consecutive cycles.
- Backpressure: port 0 head dest 1 with out_afull[1]=1, and port 1 head dest 2 -> port 1 is popped and port 0 is held. Drop out_afull[1] -> port 0 is popped next cycle.
- enable/wrap: deassert enable while streaming -> in_pop=0 that cycle and one final push the next cycle. Preload 65535 pushes and then push once more -> pkt_count=0x0000.
